// File: rtl/risc_loader.sv
// Purpose: loads a program image into CPU memory, holds the CPU in reset, then times its run until halt.
// Latency: one cycle from an accepted word to its mem_wr strobe; CPU reset is released 2 cycles after the last word.
// Backpressure: load_ready is high only in LOAD and out of reset. Optional run timeout via RISC_LOADER_TIMEOUT_EN.
module risc_loader #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8,
    parameter int CWIDTH = 16
`ifdef RISC_LOADER_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 1000
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [DWIDTH-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              start,
    input  logic              halt,
    output logic              cpu_rst,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_data,
    output logic [CWIDTH-1:0] run_cycles,
    output logic              done,
    output logic              overflow,
    output logic              timeout
);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_CPURST = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [AWIDTH-1:0] wr_ptr;
    logic              rst_cnt;
    logic              accept;
    logic              ptr_full;
    logic              run_tick;
    logic              rearm;
    logic              to_hit;

    assign accept   = load_valid && load_ready;
    assign ptr_full = (wr_ptr == {AWIDTH{1'b1}});
    assign rearm    = (state_q == S_DONE) && start;
    assign run_tick = (state_q == S_RUN) && !halt && !to_hit;

`ifdef RISC_LOADER_TIMEOUT_EN
    logic        timeout_q;
    logic [31:0] run_ext;

    // Widened so a TIMEOUT beyond the counter range is compared honestly.
    assign run_ext = 32'(run_cycles);
    assign to_hit  = (state_q == S_RUN) && (run_ext >= 32'(TIMEOUT));
    assign timeout = timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if (rearm) begin
            timeout_q <= 1'b0;
        end else if (to_hit) begin
            timeout_q <= 1'b1;
        end
    end
`else
    assign to_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD: begin
                if (accept && (load_last || ptr_full)) begin
                    state_d = S_CPURST;
                end
            end
            S_CPURST: begin
                if (rst_cnt) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (halt || to_hit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // A timed-out CPU is parked in reset; a halted one is left running.
    always_comb begin
        load_ready = 1'b0;
        cpu_rst    = 1'b1;
        done       = 1'b0;
        case (state_q)
            S_LOAD: begin
                load_ready = !rst;
            end
            S_CPURST: begin
                cpu_rst = 1'b1;
            end
            S_RUN: begin
                cpu_rst = 1'b0;
            end
            S_DONE: begin
                done    = 1'b1;
                cpu_rst = timeout;
            end
            default: begin
                cpu_rst = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            mem_wr   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            mem_wr <= accept;
            if (accept) begin
                mem_addr <= wr_ptr;
                mem_data <= load_data;
                // The pointer parks at the top word; the FSM leaves LOAD there anyway.
                if (!ptr_full) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end else if (rearm) begin
                wr_ptr <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_cnt <= 1'b0;
        end else if (state_q == S_CPURST) begin
            rst_cnt <= ~rst_cnt;
        end else begin
            rst_cnt <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cycles <= '0;
            overflow   <= 1'b0;
        end else if (rearm) begin
            run_cycles <= '0;
            overflow   <= 1'b0;
        end else if (run_tick) begin
            if (run_cycles == {CWIDTH{1'b1}}) begin
                overflow <= 1'b1;
            end else begin
                run_cycles <= run_cycles + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_risc_loader.sv
// Directed bench for risc_loader: a per-cycle vector table plus hand-written corner sequences.
// A 4-bit-counter instance shares the stimulus to exercise saturation.
module tb_risc_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       start;
    logic       halt;

    logic        load_ready, cpu_rst, mem_wr, done, overflow, timeout;
    logic [4:0]  mem_addr;
    logic [7:0]  mem_data;
    logic [15:0] run_cycles;

    logic        s_load_ready, s_cpu_rst, s_mem_wr, s_done, s_overflow, s_timeout;
    logic [4:0]  s_mem_addr;
    logic [7:0]  s_mem_data;
    logic [3:0]  s_run_cycles;

    int checks   = 0;
    int failures = 0;

    risc_loader u_dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .start(start), .halt(halt),
        .cpu_rst(cpu_rst), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data),
        .run_cycles(run_cycles), .done(done), .overflow(overflow), .timeout(timeout)
    );

    risc_loader #(.CWIDTH(4)) u_small (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(s_load_ready), .start(start), .halt(halt),
        .cpu_rst(s_cpu_rst), .mem_wr(s_mem_wr), .mem_addr(s_mem_addr), .mem_data(s_mem_data),
        .run_cycles(s_run_cycles), .done(s_done), .overflow(s_overflow), .timeout(s_timeout)
    );

`ifdef RISC_LOADER_TIMEOUT_EN
    logic        t_load_ready, t_cpu_rst, t_mem_wr, t_done, t_overflow, t_timeout;
    logic [4:0]  t_mem_addr;
    logic [7:0]  t_mem_data;
    logic [15:0] t_run_cycles;

    risc_loader #(.TIMEOUT(10)) u_to (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(t_load_ready), .start(start), .halt(halt),
        .cpu_rst(t_cpu_rst), .mem_wr(t_mem_wr), .mem_addr(t_mem_addr), .mem_data(t_mem_data),
        .run_cycles(t_run_cycles), .done(t_done), .overflow(t_overflow), .timeout(t_timeout)
    );
`endif

    typedef struct {
        logic        rst, lv, last, st, h;
        logic [7:0]  dat;
        logic        wr;
        logic [4:0]  addr;
        logic [7:0]  wdat;
        logic        rdy, crst, dn;
        logic [15:0] rc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int r, input int lv, input int d, input int last,
                                input int st, input int h, input int wr, input int a,
                                input int wd, input int rdy, input int crst, input int dn,
                                input int rc);
        vec_t v;
        v.rst  = r[0];   v.lv  = lv[0];  v.dat = d[7:0];  v.last = last[0];
        v.st   = st[0];  v.h   = h[0];   v.wr  = wr[0];   v.addr = a[4:0];
        v.wdat = wd[7:0]; v.rdy = rdy[0]; v.crst = crst[0]; v.dn = dn[0];
        v.rc   = rc[15:0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        load_valid = 1'b0;
        load_data  = 8'h00;
        load_last  = 1'b0;
        start      = 1'b0;
        halt       = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Loads a one-word image and steps through the two CPU reset cycles into RUN.
    task automatic load_one_and_run(input logic [7:0] d);
        load_valid = 1'b1; load_data = d; load_last = 1'b1;
        tick();
        idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int writes;
        int waited;

        rst = 1'b0;
        idle_inputs();

        tbl.push_back(mk(1, 1, 'hAA, 0, 0, 0,  0, 0, 'h00,  0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 'h00, 0, 0, 0,  0, 0, 'h00,  1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'hE2, 0, 0, 0,  1, 0, 'hE2,  1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'hE2, 0, 0, 0,  1, 1, 'hE2,  1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'h00, 1, 0, 0,  1, 2, 'h00,  0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 'h00, 0, 1, 1,  0, 0, 'h00,  0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'h77, 0, 0, 0,  0, 0, 'h00,  0, 0, 0, 0));
        for (int i = 1; i <= 9; i++) begin
            tbl.push_back(mk(0, 0, 'h00, 0, 0, 0,  0, 0, 'h00,  0, 0, 0, i));
        end
        tbl.push_back(mk(0, 0, 'h00, 0, 0, 1,  0, 0, 'h00,  0, 0, 1, 9));
        tbl.push_back(mk(0, 1, 'h55, 0, 0, 1,  0, 0, 'h00,  0, 0, 1, 9));
        tbl.push_back(mk(0, 0, 'h00, 0, 1, 0,  0, 0, 'h00,  1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 'h5A, 1, 0, 0,  1, 0, 'h5A,  0, 1, 0, 0));

        foreach (tbl[i]) begin
            rst        = tbl[i].rst;
            load_valid = tbl[i].lv;
            load_data  = tbl[i].dat;
            load_last  = tbl[i].last;
            start      = tbl[i].st;
            halt       = tbl[i].h;
            tick();
            chk($sformatf("T%0d_mem_wr", i), 32'(mem_wr), 32'(tbl[i].wr));
            if (tbl[i].wr || tbl[i].rst) begin
                chk($sformatf("T%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
                chk($sformatf("T%0d_mem_data", i), 32'(mem_data), 32'(tbl[i].wdat));
            end
            chk($sformatf("T%0d_load_ready", i), 32'(load_ready), 32'(tbl[i].rdy));
            chk($sformatf("T%0d_cpu_rst", i), 32'(cpu_rst), 32'(tbl[i].crst));
            chk($sformatf("T%0d_done", i), 32'(done), 32'(tbl[i].dn));
            chk($sformatf("T%0d_run_cycles", i), 32'(run_cycles), 32'(tbl[i].rc));
            chk($sformatf("T%0d_overflow", i), 32'(overflow), 32'd0);
        end

        // 40-word stream without load_last: the memory fills at 32 words.
        do_reset();
        writes = 0;
        for (int i = 0; i < 40; i++) begin
            load_valid = 1'b1;
            load_data  = 8'(i);
            load_last  = 1'b0;
            tick();
            if (mem_wr === 1'b1) begin
                chk("A_addr", 32'(mem_addr), 32'(writes));
                chk("A_data", 32'(mem_data), 32'(writes));
                writes++;
            end
            if (i == 30) chk("A_ready_before_full", 32'(load_ready), 32'd1);
            if (i == 31) begin
                chk("A_ready_drop", 32'(load_ready), 32'd0);
                chk("A_cpurst_entered", 32'(cpu_rst), 32'd1);
            end
            if (i == 33) chk("A_run_entered", 32'(cpu_rst), 32'd0);
        end
        idle_inputs();
        chk("A_write_count", 32'(writes), 32'd32);

        // Counter saturation on the 4-bit instance; 16-bit instance counts exactly.
        do_reset();
        load_one_and_run(8'hE2);
        chk("B_cpu_rst_low", 32'(cpu_rst), 32'd0);
        for (int i = 0; i < 20; i++) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("B_done", 32'(done), 32'd1);
        chk("B_run_cycles", 32'(run_cycles), 32'd20);
        chk("B_overflow", 32'(overflow), 32'd0);
        chk("B_small_done", 32'(s_done), 32'd1);
        chk("B_small_run_cycles", 32'(s_run_cycles), 32'd15);
        chk("B_small_overflow", 32'(s_overflow), 32'd1);
        tick();
        chk("B_small_overflow_held", 32'(s_overflow), 32'd1);

        // Reset in RUN, start ignored in LOAD, reset abandons a pending write.
        do_reset();
        load_one_and_run(8'h01);
        for (int i = 0; i < 5; i++) tick();
        chk("C_run5", 32'(run_cycles), 32'd5);
        rst = 1'b1;
        tick();
        chk("C_rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("C_rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("C_rst_mem_data", 32'(mem_data), 32'd0);
        chk("C_rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("C_rst_load_ready", 32'(load_ready), 32'd0);
        chk("C_rst_done", 32'(done), 32'd0);
        chk("C_rst_run_cycles", 32'(run_cycles), 32'd0);
        chk("C_rst_overflow", 32'(overflow), 32'd0);
        chk("C_rst_timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("C_start_ignored_ready", 32'(load_ready), 32'd1);
        chk("C_start_ignored_done", 32'(done), 32'd0);
        chk("C_start_ignored_cpu_rst", 32'(cpu_rst), 32'd1);
        load_valid = 1'b1; load_data = 8'h3C;
        tick();
        chk("C_first_wr", 32'(mem_wr), 32'd1);
        chk("C_first_addr", 32'(mem_addr), 32'd0);
        chk("C_first_data", 32'(mem_data), 32'h3C);
        rst = 1'b1; load_data = 8'h99;
        tick();
        chk("C_pending_dropped", 32'(mem_wr), 32'd0);
        rst = 1'b0; load_valid = 1'b0;
        tick();
        chk("C_idle_no_wr", 32'(mem_wr), 32'd0);
        load_valid = 1'b1; load_data = 8'h11; load_last = 1'b1;
        tick();
        idle_inputs();
        chk("C_reload_wr", 32'(mem_wr), 32'd1);
        chk("C_reload_addr", 32'(mem_addr), 32'd0);
        chk("C_reload_data", 32'(mem_data), 32'h11);

`ifdef RISC_LOADER_TIMEOUT_EN
        do_reset();
        load_one_and_run(8'hE2);
        waited = 0;
        while (t_done !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        chk("D_done_within_budget", 32'(t_done), 32'd1);
        chk("D_timeout", 32'(t_timeout), 32'd1);
        chk("D_run_cycles", 32'(t_run_cycles), 32'd10);
        chk("D_cpu_rst", 32'(t_cpu_rst), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("D_timeout_cleared", 32'(t_timeout), 32'd0);
        chk("D_run_cleared", 32'(t_run_cycles), 32'd0);
`else
        waited = 0;
        chk("D_timeout_const", 32'(timeout | s_timeout), 32'(waited));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
